// File: rtl/fsbm_search_ctrl.sv
// -----------------------------------------------------------------------------
// fsbm_search_ctrl
//   Sequencer for one full-search block-matching pass. It walks the current
//   block pixel by pixel and issues matching read addresses to the current-block
//   and reference-window memories. It clears and steps the SAD PE array, pulses
//   the compare stage, and captures the packed {mad, mv} result.
//
// Optional feature (compile-time macro FSBM_SEARCH_CNT_EN):
//   When the macro is defined, the module adds a search_cnt[15:0] output. It
//   counts completed searches, saturates at 16'hFFFF and is cleared only by reset.
//
// Ports:
//   clk        in   1       clock, all logic on posedge
//   rst_n      in   1       synchronous active-low reset
//   start      in   1       request a search (sampled only in IDLE)
//   abort      in   1       cancel the running search
//   busy       out  1       high in every state except IDLE
//   cur_rd     out  1       current-block memory read strobe
//   cur_addr   out  ADDR_W  current-block pixel address r*BLK + c
//   ref_rd     out  1       reference-window read strobe (same cycles as cur_rd)
//   ref_addr   out  ADDR_W  reference-window base address r*(BLK+SRCH-1) + c
//   pe_clear   out  1       one-cycle clear of all PE accumulators
//   pe_acc     out  1       PE accumulate valid, one cycle behind the reads
//   cmp_enable out  1       one-cycle enable into the compare stage
//   cmp_out    in   20      compare result {mad[11:0], mv[7:0]}
//   result     out  20      captured {mad, mv}; held until the next capture
//   done       out  1       one-cycle pulse; result is valid in the same cycle
//   search_cnt out  16      completed-search count (FSBM_SEARCH_CNT_EN only)
// -----------------------------------------------------------------------------
module fsbm_search_ctrl #(
   parameter int BLK     = 4,
   parameter int SRCH    = 4,
   parameter int ADDR_W  = 8,
   parameter int CMP_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              cur_rd,
   output logic [ADDR_W-1:0] cur_addr,
   output logic              ref_rd,
   output logic [ADDR_W-1:0] ref_addr,
   output logic              pe_clear,
   output logic              pe_acc,
   output logic              cmp_enable,
   input  logic [19:0]       cmp_out,
   output logic [19:0]       result,
   output logic              done
`ifdef FSBM_SEARCH_CNT_EN
   ,
   output logic [15:0]       search_cnt
`endif
);

   localparam int RC_W = (BLK > 1) ? $clog2(BLK) : 1;
   localparam int WC_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

   localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(BLK - 1);
   localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(CMP_LAT - 1);
   localparam logic [ADDR_W-1:0] BLK_A     = ADDR_W'(BLK);
   localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(BLK + SRCH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_DRAIN,
      S_CMP,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [RC_W-1:0]   r_q, r_d;
   logic [RC_W-1:0]   c_q, c_d;
   logic [WC_W-1:0]   wait_q, wait_d;
   logic [19:0]       result_q, result_d;
   logic              busy_q, busy_d;
   logic              pe_clear_q, pe_clear_d;
   logic              cur_rd_q, cur_rd_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
   logic              pe_acc_q, pe_acc_d;
   logic              cmp_enable_q, cmp_enable_d;
   logic              done_q, done_d;
   logic [15:0]       cnt_q, cnt_d;

   // Next-state and next-output logic. All outputs come from registers, so
   // each output is derived from the state being entered.
   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      c_d      = c_q;
      wait_d   = wait_q;
      result_d = result_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = S_ACCUM;
            r_d     = '0;
            c_d     = '0;
         end
         S_ACCUM: begin
            // The walk is raster order. The last pixel (BLK-1,BLK-1) ends the read phase.
            if (c_q == RC_LAST) begin
               c_d = '0;
               if (r_q == RC_LAST) begin
                  r_d     = '0;
                  state_d = S_DRAIN;
               end else begin
                  r_d = r_q + 1'b1;
               end
            end else begin
               c_d = c_q + 1'b1;
            end
         end
         S_DRAIN: state_d = S_CMP;
         S_CMP: begin
            state_d = S_WAIT;
            wait_d  = '0;
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               result_d = cmp_out;
               state_d  = S_DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort overrides every transition, including the result capture on
      // the final WAIT edge.
      if (abort && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         r_d      = '0;
         c_d      = '0;
         wait_d   = '0;
         result_d = result_q;
      end

      if ((state_q == S_WAIT) && (state_d == S_DONE) && (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;

      busy_d       = (state_d != S_IDLE);
      pe_clear_d   = (state_d == S_CLEAR);
      cur_rd_d     = (state_d == S_ACCUM);
      cur_addr_d   = cur_rd_d ? (ADDR_W'(r_d) * BLK_A + ADDR_W'(c_d)) : '0;
      ref_addr_d   = cur_rd_d ? (ADDR_W'(r_d) * STRIDE_A + ADDR_W'(c_d)) : '0;
      // pe_acc follows the reads by one cycle (memory latency). It drops at once on abort.
      pe_acc_d     = cur_rd_q && (state_d != S_IDLE);
      cmp_enable_d = (state_d == S_CMP);
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         r_q          <= '0;
         c_q          <= '0;
         wait_q       <= '0;
         result_q     <= '0;
         busy_q       <= 1'b0;
         pe_clear_q   <= 1'b0;
         cur_rd_q     <= 1'b0;
         cur_addr_q   <= '0;
         ref_addr_q   <= '0;
         pe_acc_q     <= 1'b0;
         cmp_enable_q <= 1'b0;
         done_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         c_q          <= c_d;
         wait_q       <= wait_d;
         result_q     <= result_d;
         busy_q       <= busy_d;
         pe_clear_q   <= pe_clear_d;
         cur_rd_q     <= cur_rd_d;
         cur_addr_q   <= cur_addr_d;
         ref_addr_q   <= ref_addr_d;
         pe_acc_q     <= pe_acc_d;
         cmp_enable_q <= cmp_enable_d;
         done_q       <= done_d;
         cnt_q        <= cnt_d;
      end
   end

   assign busy       = busy_q;
   assign cur_rd     = cur_rd_q;
   assign cur_addr   = cur_addr_q;
   assign ref_rd     = cur_rd_q;
   assign ref_addr   = ref_addr_q;
   assign pe_clear   = pe_clear_q;
   assign pe_acc     = pe_acc_q;
   assign cmp_enable = cmp_enable_q;
   assign result     = result_q;
   assign done       = done_q;

`ifdef FSBM_SEARCH_CNT_EN
   assign search_cnt = cnt_q;
`else
   // Without the count port, the counter has no load and is trimmed away.
   logic unused_cnt;
   assign unused_cnt = ^cnt_q;
`endif

endmodule
